flush_redirect_ctrl: RTL

//  Consumer of the per-way branch-resolution flush vector from EX. Arbitrates

---
 rtl/flush_redirect_ctrl.sv | 112 +++++++++++
 1 files changed

// File: rtl/flush_redirect_ctrl.sv
// Arbitrates the EX-stage branch flush vector (way0 older), kills the younger
// way, issues a one-cycle PC redirect and sequences the IF/ID drain window.
module flush_redirect_ctrl #(
    parameter int ADDR_W       = 32,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        ex_valid,
    input  logic [1:0]        is_flush,
    input  logic [ADDR_W-1:0] target0,
    input  logic [ADDR_W-1:0] target1,
    input  logic              stall_in,
    output logic              kill_ex_way1,
    output logic              redirect_valid,
    output logic [ADDR_W-1:0] redirect_pc,
    output logic              flush_ifid,
    output logic              flush_idex,
    output logic              busy,
    output logic [CNT_W-1:0]  flush_count
);

    localparam int DCNT_W = (FLUSH_CYCLES > 2) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [DCNT_W-1:0] DRAIN_INIT =
        (FLUSH_CYCLES >= 2) ? DCNT_W'(FLUSH_CYCLES - 2) : '0;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REDIRECT = 2'd1,
        DRAIN    = 2'd2
    } state_t;

    state_t              state_reg;
    logic [DCNT_W-1:0]   drain_cnt_reg;
    logic                redirect_valid_reg;
    logic [ADDR_W-1:0]   redirect_pc_reg;
    logic                flush_ifid_reg;
    logic                flush_idex_reg;
    logic [CNT_W-1:0]    flush_count_reg;

    logic [1:0]          take;
    logic                accept;
    logic [ADDR_W-1:0]   sel_target;

    // Wrong-path EX contents while redirecting/draining are ignored via the IDLE gate.
    assign take       = is_flush & ex_valid;
    assign accept     = (state_reg == IDLE) && !stall_in && (take != 2'b00);
    assign sel_target = take[0] ? target0 : target1;

    assign kill_ex_way1   = accept && take[0];
    assign redirect_valid = redirect_valid_reg;
    assign redirect_pc    = redirect_pc_reg;
    assign flush_ifid     = flush_ifid_reg;
    assign flush_idex     = flush_idex_reg;
    assign busy           = (state_reg != IDLE);
    assign flush_count    = flush_count_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg          <= IDLE;
            drain_cnt_reg      <= '0;
            redirect_valid_reg <= 1'b0;
            redirect_pc_reg    <= '0;
            flush_ifid_reg     <= 1'b0;
            flush_idex_reg     <= 1'b0;
            flush_count_reg    <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        state_reg          <= REDIRECT;
                        redirect_pc_reg    <= sel_target;
                        redirect_valid_reg <= 1'b1;
                        flush_ifid_reg     <= 1'b1;
                        flush_idex_reg     <= 1'b1;
                        if (flush_count_reg != {CNT_W{1'b1}}) begin
                            flush_count_reg <= flush_count_reg + 1'b1;
                        end
                    end
                end
                REDIRECT: begin
                    redirect_valid_reg <= 1'b0;
                    flush_idex_reg     <= 1'b0;
                    if (FLUSH_CYCLES == 1) begin
                        state_reg      <= IDLE;
                        flush_ifid_reg <= 1'b0;
                    end else begin
                        state_reg      <= DRAIN;
                        drain_cnt_reg  <= DRAIN_INIT;
                        flush_ifid_reg <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (drain_cnt_reg == '0) begin
                        state_reg      <= IDLE;
                        flush_ifid_reg <= 1'b0;
                    end else begin
                        drain_cnt_reg  <= drain_cnt_reg - 1'b1;
                    end
                end
                default: begin
                    state_reg          <= IDLE;
                    redirect_valid_reg <= 1'b0;
                    flush_ifid_reg     <= 1'b0;
                    flush_idex_reg     <= 1'b0;
                end
            endcase
        end
    end

endmodule
